regfile_writeback: RTL and testbench

- Sole producer of the register file's write port (wr_en / wr_reg / wr_data).
- Merges two result sources into that port: single-cycle pipeline results (ALU/load, no backpressure) and long-latency unit results (mul/div, valid/ready). Long-latency results are buffered in a small FIFO.
- Keeps a pending-register scoreboard so decode can stall on registers awaiting long-latency results.

---
 rtl/regfile_writeback.sv | 129 ++++++++++++
 tb/tb_regfile_writeback.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// Register-file write-back merger: pipeline results vs. buffered
// long-latency results, plus a pending-register scoreboard for decode.
module regfile_writeback #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pipe_wr_en,
    input  logic [4:0]       pipe_wr_reg,
    input  logic [31:0]      pipe_wr_data,
    input  logic             lat_valid,
    output logic             lat_ready,
    input  logic [4:0]       lat_reg,
    input  logic [31:0]      lat_data,
    input  logic             issue_en,
    input  logic [4:0]       issue_reg,
    input  logic [4:0]       chk1_reg,
    input  logic [4:0]       chk2_reg,
    output logic             chk1_busy,
    output logic             chk2_busy,
    output logic             wr_en,
    output logic [4:0]       wr_reg,
    output logic [31:0]      wr_data,
    output logic [CNT_W-1:0] fifo_count,
    output logic             err_unexpected
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [4:0]       q_reg  [DEPTH];
    logic [31:0]      q_data [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [31:0]      pending;
    logic [31:0]      pending_nxt;

    logic accept;
    logic push;
    logic pipe_go;
    logic pop;
    logic [4:0] head_reg;

    assign lat_ready = (fifo_count < FULL);
    assign accept    = lat_valid && lat_ready;
    // x0 results are acknowledged but never stored.
    assign push      = accept && (lat_reg != 5'd0);
    assign pipe_go   = pipe_wr_en && (pipe_wr_reg != 5'd0);
    assign pop       = !pipe_go && (fifo_count != '0);
    assign head_reg  = q_reg[rd_ptr];

    assign chk1_busy = pending[chk1_reg];
    assign chk2_busy = pending[chk2_reg];

    // Scoreboard next state: clear on pop, then set on issue so set wins.
    always_comb begin
        pending_nxt = pending;
        if (pop) begin
            pending_nxt[head_reg] = 1'b0;
        end
        if (issue_en) begin
            pending_nxt[issue_reg] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    // FIFO payload storage; contents are only meaningful below fifo_count.
    always_ff @(posedge clk) begin
        if (push) begin
            q_reg[wr_ptr]  <= lat_reg;
            q_data[wr_ptr] <= lat_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Write-port arbitration: pipeline first, then FIFO head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_reg  <= '0;
            wr_data <= '0;
        end else if (pipe_go) begin
            wr_en   <= 1'b1;
            wr_reg  <= pipe_wr_reg;
            wr_data <= pipe_wr_data;
        end else if (pop) begin
            wr_en   <= 1'b1;
            wr_reg  <= head_reg;
            wr_data <= q_data[rd_ptr];
        end else begin
            wr_en   <= 1'b0;
        end
    end

    // Pending bits and the sticky unexpected-result flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending        <= '0;
            err_unexpected <= 1'b0;
        end else begin
            pending <= pending_nxt;
            if (accept && !pending[lat_reg]) begin
                err_unexpected <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: arbitration, FIFO, scoreboard,
// error flag and asynchronous reset.
module tb_regfile_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_wr_en;
    logic [4:0]  pipe_wr_reg;
    logic [31:0] pipe_wr_data;
    logic        lat_valid;
    logic        lat_ready;
    logic [4:0]  lat_reg;
    logic [31:0] lat_data;
    logic        issue_en;
    logic [4:0]  issue_reg;
    logic [4:0]  chk1_reg;
    logic [4:0]  chk2_reg;
    logic        chk1_busy;
    logic        chk2_busy;
    logic        wr_en;
    logic [4:0]  wr_reg;
    logic [31:0] wr_data;
    logic [2:0]  fifo_count;
    logic        err_unexpected;

    int tests = 0;
    int fails = 0;

    regfile_writeback #(.DEPTH(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pipe_wr_en     (pipe_wr_en),
        .pipe_wr_reg    (pipe_wr_reg),
        .pipe_wr_data   (pipe_wr_data),
        .lat_valid      (lat_valid),
        .lat_ready      (lat_ready),
        .lat_reg        (lat_reg),
        .lat_data       (lat_data),
        .issue_en       (issue_en),
        .issue_reg      (issue_reg),
        .chk1_reg       (chk1_reg),
        .chk2_reg       (chk2_reg),
        .chk1_busy      (chk1_busy),
        .chk2_busy      (chk2_busy),
        .wr_en          (wr_en),
        .wr_reg         (wr_reg),
        .wr_data        (wr_data),
        .fifo_count     (fifo_count),
        .err_unexpected (err_unexpected)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_wr(input string tag, input logic en,
                            input logic [4:0] r, input logic [31:0] d);
        check({tag, ".wr_en"}, 32'(wr_en), 32'(en));
        check({tag, ".wr_reg"}, 32'(wr_reg), 32'(r));
        check({tag, ".wr_data"}, wr_data, d);
    endtask

    initial begin
        rst_n = 1'b0;
        pipe_wr_en = 1'b0;
        pipe_wr_reg = '0;
        pipe_wr_data = '0;
        lat_valid = 1'b0;
        lat_reg = '0;
        lat_data = '0;
        issue_en = 1'b0;
        issue_reg = '0;
        chk1_reg = '0;
        chk2_reg = '0;
        tick();
        tick();
        check_wr("rst", 1'b0, 5'd0, 32'h0);
        check("rst.count", 32'(fifo_count), 32'd0);
        check("rst.err", 32'(err_unexpected), 32'd0);
        check("rst.ready", 32'(lat_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        // 1: pipeline write, then a dropped x0 write
        pipe_wr_en = 1'b1;
        pipe_wr_reg = 5'd5;
        pipe_wr_data = 32'hDEADBEEF;
        tick();
        check_wr("t1.pipe", 1'b1, 5'd5, 32'hDEADBEEF);
        pipe_wr_reg = 5'd0;
        pipe_wr_data = 32'h11111111;
        tick();
        check_wr("t1.x0", 1'b0, 5'd5, 32'hDEADBEEF);
        pipe_wr_en = 1'b0;

        // 2: issue, busy, long-latency write-back
        issue_en = 1'b1;
        issue_reg = 5'd7;
        tick();
        issue_en = 1'b0;
        chk1_reg = 5'd7;
        #1;
        check("t2.busy", 32'(chk1_busy), 32'd1);
        lat_valid = 1'b1;
        lat_reg = 5'd7;
        lat_data = 32'h1234;
        tick();
        lat_valid = 1'b0;
        check("t2.count", 32'(fifo_count), 32'd1);
        check("t2.early", 32'(wr_en), 32'd0);
        tick();
        check_wr("t2.wb", 1'b1, 5'd7, 32'h1234);
        check("t2.busy0", 32'(chk1_busy), 32'd0);
        check("t2.err", 32'(err_unexpected), 32'd0);
        tick();
        check("t2.idle", 32'(wr_en), 32'd0);

        // 3: fill under pipeline pressure, then drain in order
        pipe_wr_en = 1'b1;
        pipe_wr_reg = 5'd1;
        pipe_wr_data = 32'hAAAA0000;
        issue_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue_reg = 5'(10 + i);
            tick();
        end
        issue_en = 1'b0;
        lat_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            lat_reg = 5'(10 + i);
            lat_data = 32'h100 + 32'(i);
            tick();
        end
        check("t3.count", 32'(fifo_count), 32'd4);
        check("t3.ready", 32'(lat_ready), 32'd0);
        check_wr("t3.pipe", 1'b1, 5'd1, 32'hAAAA0000);
        lat_reg = 5'd20;
        lat_data = 32'hBAD;
        tick();
        lat_valid = 1'b0;
        check("t3.full", 32'(fifo_count), 32'd4);
        pipe_wr_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_wr($sformatf("t3.d%0d", i), 1'b1, 5'(10 + i),
                     32'h100 + 32'(i));
            check($sformatf("t3.c%0d", i), 32'(fifo_count), 32'(3 - i));
            check($sformatf("t3.r%0d", i), 32'(lat_ready), 32'd1);
        end
        tick();
        check("t3.idle", 32'(wr_en), 32'd0);
        chk1_reg = 5'd10;
        #1;
        check("t3.busy", 32'(chk1_busy), 32'd0);
        check("t3.err", 32'(err_unexpected), 32'd0);

        // 4: re-issue of reg 3 on the cycle its entry pops
        issue_en = 1'b1;
        issue_reg = 5'd3;
        tick();
        issue_en = 1'b0;
        lat_valid = 1'b1;
        lat_reg = 5'd3;
        lat_data = 32'h33;
        tick();
        lat_valid = 1'b0;
        issue_en = 1'b1;
        issue_reg = 5'd3;
        tick();
        issue_en = 1'b0;
        chk2_reg = 5'd3;
        #1;
        check_wr("t4.wb", 1'b1, 5'd3, 32'h33);
        check("t4.busy", 32'(chk2_busy), 32'd1);
        tick();
        check("t4.busy2", 32'(chk2_busy), 32'd1);

        // 5: unexpected results, including x0
        lat_valid = 1'b1;
        lat_reg = 5'd9;
        lat_data = 32'h99;
        tick();
        lat_valid = 1'b0;
        check("t5.err", 32'(err_unexpected), 32'd1);
        tick();
        check_wr("t5.wb", 1'b1, 5'd9, 32'h99);
        tick();
        check("t5.sticky", 32'(err_unexpected), 32'd1);
        lat_valid = 1'b1;
        lat_reg = 5'd0;
        lat_data = 32'h77;
        tick();
        lat_valid = 1'b0;
        check("t5.x0cnt", 32'(fifo_count), 32'd0);
        tick();
        check_wr("t5.x0", 1'b0, 5'd9, 32'h99);
        check("t5.err2", 32'(err_unexpected), 32'd1);

        // 6: asynchronous reset with a partly full FIFO
        issue_en = 1'b1;
        issue_reg = 5'd20;
        tick();
        issue_reg = 5'd21;
        tick();
        issue_en = 1'b0;
        pipe_wr_en = 1'b1;
        pipe_wr_reg = 5'd2;
        pipe_wr_data = 32'h2;
        lat_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            lat_reg = (i == 1) ? 5'd21 : 5'd20;
            lat_data = 32'h600 + 32'(i);
            tick();
        end
        lat_valid = 1'b0;
        chk1_reg = 5'd20;
        chk2_reg = 5'd21;
        #1;
        check("t6.count", 32'(fifo_count), 32'd3);
        check("t6.pre", 32'(chk1_busy & chk2_busy), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_wr("t6.rst", 1'b0, 5'd0, 32'h0);
        check("t6.cnt0", 32'(fifo_count), 32'd0);
        check("t6.b1", 32'(chk1_busy), 32'd0);
        check("t6.b2", 32'(chk2_busy), 32'd0);
        check("t6.err", 32'(err_unexpected), 32'd0);
        pipe_wr_en = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("t6.ready", 32'(lat_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t6.stale%0d", i), 32'(wr_en), 32'd0);
        end
        check("t6.cnt1", 32'(fifo_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
